sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//  Multi-cycle data-RAM slave sitting directly downstream of mem_controller's arbitrated bus.
//  It accepts one bus transfer at a time, inserts programmable wait states, then commits or
//  returns a 64-bit dword. Byte-lane writes and range/alignment errors are reported back to
//  the requesting stage, which stalls until completion.
// PARAMETERS
//  BASE_ADDR    64'h8000_0000  first byte address decoded by this slave
//  DEPTH_WORDS  4096           number of 64-bit words in the array (power of two)
//  WAIT_STATES  1              extra busy cycles per transfer, 0..15
// PORTS
//  CLK     in   1   clock, all state on rising edge
//  RESET   in   1   asynchronous, active-high reset
//  HTRANS  in   1   transfer request, sampled only when HREADY=1
//  HADDR   in   64  byte address
//  HWRITE  in   1   1=write, 0=read
//  HSIZE   in   3   0=byte 1=half 2=word 3=dword
//  HWDATA  in   64  write data, lane-aligned (byte k in bits 8k+7:8k)
//  HREADY  out  1   1=idle/able to accept; 0=transfer in flight (drives stall)
//  RVALID  out  1   one-cycle pulse: transfer complete, HRDATA/HRESP valid
//  HRDATA  out  64  full aligned dword at HADDR[63:3] (reads); holds last value otherwise
//  HRESP   out  1   valid with RVALID: 1=error (no write committed, HRDATA=0)
// BEHAVIOUR
//  Reset: state=IDLE, HREADY=1, RVALID=0, HRDATA=0, HRESP=0, counter=0. Array NOT cleared.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: HREADY=1. HTRANS=1 at edge: latch HADDR/HWRITE/HSIZE/HWDATA, counter<=WAIT_STATES,
//   go BUSY. HTRANS=0: stay.
//  BUSY: HREADY=0. counter!=0: decrement. counter==0: perform access at edge, go DONE.
//  DONE: RVALID=1, HREADY=1 for exactly one cycle. HTRANS=1 here is accepted (back-to-back,
//   -> BUSY); else -> IDLE.
//  Latency: request accepted at edge N -> RVALID high in cycle after edge N+WAIT_STATES+1.
//   HREADY low for WAIT_STATES+1 cycles.
//  Decode: index=(HADDR-BASE_ADDR)>>3, 64-bit subtraction.
//   Out of range (HADDR<BASE_ADDR or index>=DEPTH_WORDS): error.
//  Alignment: HADDR must be a multiple of 2^HSIZE; else error. HSIZE>3: error.
//  Error: HRESP=1, HRDATA=0, array untouched, same latency as success.
//  Write: byte-enable mask = (2^(2^HSIZE))-1 << HADDR[2:0]. Only enabled bytes updated.
//   HRDATA after write = dword contents post-write.
//  Read: HRDATA = array[index], 64-bit, no sign/zero extension (done by mem_access).
//  Inputs are ignored while HREADY=0 (latched copy used); changes mid-transfer have no effect.
//  RESET asserted mid-transfer: abort immediately, no write committed, FSM to IDLE.
//  WAIT_STATES=0: BUSY lasts one cycle.
// TESTING
//  1 WS=1: write dword 64'h1122334455667788 @BASE, then read @BASE ->
//    HRDATA=64'h1122334455667788, HRESP=0, RVALID 3 cycles after accept edge.
//  2 Byte write 8'hAB @BASE+5 (HSIZE=0, HWDATA[47:40]=AB) over case-1 data ->
//    read returns 64'h1122AB4455667788.
//  3 Half write @BASE+3 -> HRESP=1, HRDATA=0; following read of BASE unchanged.
//  4 Read @BASE-8 and @BASE+DEPTH_WORDS*8 -> both HRESP=1; HREADY timing identical to success.
//  5 Back-to-back: HTRANS held high during DONE -> second transfer accepted with no IDLE cycle;
//    WS=0 gives RVALID every 2nd cycle.
//  6 Assert RESET in BUSY of a write @BASE+16 -> HREADY=1, RVALID=0 immediately;
//    later read @BASE+16 shows old contents.

Source files
------------

// File: rtl/sram_ctrl.sv
// Multi-cycle 64-bit data RAM slave with programmable wait states,
// byte-lane writes and range/alignment error reporting.
module sram_ctrl #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HTRANS,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [63:0] HWDATA,
  output logic        HREADY,
  output logic        RVALID,
  output logic [63:0] HRDATA,
  output logic        HRESP
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] a_addr;
  logic [63:0] a_wdata;
  logic        a_write;
  logic [2:0]  a_size;

  logic [63:0] mem [DEPTH_WORDS];

  logic [60:0]   off_w;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          aligned;
  logic          err;
  logic [7:0]    be_base;
  logic [7:0]    be;
  logic [63:0]   cur;
  logic [63:0]   merged;
  logic          commit;

  // Decode runs on the latched request so mid-transfer bus changes are inert.
  always_comb begin
    off_w    = a_addr[63:3] - BASE_ADDR[63:3];
    idx      = off_w[IW-1:0];
    in_range = (a_addr >= BASE_ADDR)
            && (off_w < 61'(DEPTH_WORDS));
    aligned  = 1'b0;
    be_base  = 8'h00;
    unique case (a_size)
      3'd0: begin
        aligned = 1'b1;
        be_base = 8'h01;
      end
      3'd1: begin
        aligned = (a_addr[0] == 1'b0);
        be_base = 8'h03;
      end
      3'd2: begin
        aligned = (a_addr[1:0] == 2'b00);
        be_base = 8'h0f;
      end
      3'd3: begin
        aligned = (a_addr[2:0] == 3'b000);
        be_base = 8'hff;
      end
      default: begin
        aligned = 1'b0;
        be_base = 8'h00;
      end
    endcase
    err    = !(in_range && aligned);
    be     = be_base << a_addr[2:0];
    cur    = mem[idx];
    merged = cur;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) merged[8*b +: 8] = a_wdata[8*b +: 8];
    end
    commit = (state == BUSY) && (cnt == 4'd0)
          && a_write && !err;
  end

  // A reset at the commit edge must suppress the write.
  always_ff @(posedge CLK) begin
    if (commit && !RESET) mem[idx] <= merged;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      HREADY  <= 1'b1;
      RVALID  <= 1'b0;
      HRDATA  <= 64'd0;
      HRESP   <= 1'b0;
      a_addr  <= 64'd0;
      a_wdata <= 64'd0;
      a_write <= 1'b0;
      a_size  <= 3'd0;
    end else begin
      RVALID <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (HTRANS) begin
            a_addr  <= HADDR;
            a_wdata <= HWDATA;
            a_write <= HWRITE;
            a_size  <= HSIZE;
            cnt     <= 4'(WAIT_STATES);
            state   <= BUSY;
            HREADY  <= 1'b0;
          end else begin
            state  <= IDLE;
            HREADY <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state  <= DONE;
            HREADY <= 1'b1;
            RVALID <= 1'b1;
            HRESP  <= err;
            if (err)          HRDATA <= 64'd0;
            else if (a_write) HRDATA <= merged;
            else              HRDATA <= cur;
          end
        end
        default: begin
          state  <= IDLE;
          HREADY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: WS=1 main instance plus a WS=0
// instance for back-to-back throughput.
module tb_sram_ctrl;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 64;
  localparam int          WS    = 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HTRANS, HWRITE;
  logic [63:0] HADDR, HWDATA;
  logic [2:0]  HSIZE;
  logic        HREADY, RVALID, HRESP;
  logic [63:0] HRDATA;

  logic        t0, w0;
  logic [63:0] a0, d0;
  logic [2:0]  s0;
  logic        rdy0, rv0, rsp0;
  logic [63:0] rd0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [64:0] sb [$];

  always #5 CLK = ~CLK;

  sram_ctrl #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .HTRANS(HTRANS),
    .HADDR (HADDR),
    .HWRITE(HWRITE),
    .HSIZE (HSIZE),
    .HWDATA(HWDATA),
    .HREADY(HREADY),
    .RVALID(RVALID),
    .HRDATA(HRDATA),
    .HRESP (HRESP)
  );

  sram_ctrl #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(0)
  ) dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .HTRANS(t0),
    .HADDR (a0),
    .HWRITE(w0),
    .HSIZE (s0),
    .HWDATA(d0),
    .HREADY(rdy0),
    .RVALID(rv0),
    .HRDATA(rd0),
    .HRESP (rsp0)
  );

  task automatic chk(input string tag,
                     input logic [64:0] got,
                     input logic [64:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge CLK) begin
    if (!RESET && RVALID) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 65'd1, 65'd0);
      end else begin
        logic [64:0] e;
        e = sb.pop_front();
        chk("hresp", {64'd0, HRESP}, {64'd0, e[64]});
        chk("hrdata", {1'b0, HRDATA}, {1'b0, e[63:0]});
        chk("done_rdy", {64'd0, HREADY}, 65'd1);
      end
    end
  end

  task automatic do_xfer(input logic        w,
                         input logic [63:0] a,
                         input logic [2:0]  s,
                         input logic [63:0] d,
                         input logic        eresp,
                         input logic [63:0] edata);
    int lat;
    int lo;
    @(negedge CLK);
    chk("idle_rdy", {64'd0, HREADY}, 65'd1);
    HTRANS = 1'b1;
    HWRITE = w;
    HADDR  = a;
    HSIZE  = s;
    HWDATA = d;
    sb.push_back({eresp, edata});
    @(posedge CLK);
    #1;
    // Scramble the bus: the slave must use its latched copy.
    HTRANS = 1'b0;
    HWRITE = ~w;
    HADDR  = {$urandom, $urandom};
    HWDATA = {$urandom, $urandom};
    HSIZE  = 3'($urandom);
    lat = 0;
    lo  = 0;
    while (lat < 40) begin
      @(negedge CLK);
      lat++;
      if (!HREADY) lo++;
      if (RVALID) break;
    end
    chk("latency", 65'(lat), 65'(WS + 2));
    chk("rdy_low", 65'(lo), 65'(WS + 1));
  endtask

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D2 = 64'h1122_AB44_5566_7788;
  localparam logic [63:0] D3 = 64'hCAFE_BABE_5566_7788;
  localparam logic [63:0] DA = 64'hA5A5_0F0F_5A5A_F0F0;
  localparam logic [63:0] DB = 64'h0BAD_F00D_DEAD_BEEF;

  initial begin
    RESET  = 1'b1;
    HTRANS = 1'b0;
    HWRITE = 1'b0;
    HADDR  = '0;
    HSIZE  = '0;
    HWDATA = '0;
    t0 = 1'b0;
    w0 = 1'b0;
    a0 = '0;
    s0 = '0;
    d0 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_rdy", {64'd0, HREADY}, 65'd1);
    chk("rst_rv", {64'd0, RVALID}, 65'd0);
    chk("rst_data", {1'b0, HRDATA}, 65'd0);
    chk("rst_resp", {64'd0, HRESP}, 65'd0);
    RESET = 1'b0;

    do_xfer(1, BASE, 3'd3, D1, 0, D1);
    do_xfer(0, BASE, 3'd3, 64'd0, 0, D1);
    do_xfer(1, BASE + 5, 3'd0, 64'h0000_AB00_0000_0000, 0, D2);
    do_xfer(0, BASE, 3'd3, 64'd0, 0, D2);
    do_xfer(1, BASE + 3, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
    do_xfer(0, BASE, 3'd3, 64'd0, 0, D2);
    do_xfer(1, BASE + 4, 3'd2, 64'hCAFE_BABE_0000_0000, 0, D3);
    do_xfer(1, BASE, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
    do_xfer(0, BASE, 3'd3, 64'd0, 0, D3);
    do_xfer(0, BASE - 8, 3'd3, 64'd0, 1, 64'd0);
    do_xfer(0, BASE + DEPTH * 8, 3'd3, 64'd0, 1, 64'd0);
    do_xfer(1, BASE + (DEPTH - 1) * 8, 3'd3, DB, 0, DB);
    do_xfer(0, BASE + (DEPTH - 1) * 8, 3'd3, 64'd0, 0, DB);

    // Abort a write one edge before it would commit.
    do_xfer(1, BASE + 16, 3'd3, DA, 0, DA);
    @(negedge CLK);
    HTRANS = 1'b1;
    HWRITE = 1'b1;
    HADDR  = BASE + 16;
    HSIZE  = 3'd3;
    HWDATA = DB;
    @(posedge CLK);
    #1;
    HTRANS = 1'b0;
    repeat (WS + 1) @(negedge CLK);
    chk("busy_rdy", {64'd0, HREADY}, 65'd0);
    RESET = 1'b1;
    #1;
    chk("abort_rdy", {64'd0, HREADY}, 65'd1);
    chk("abort_rv", {64'd0, RVALID}, 65'd0);
    @(negedge CLK);
    RESET = 1'b0;
    do_xfer(0, BASE + 16, 3'd3, 64'd0, 0, DA);

    // WS=0 instance: HTRANS held high gives RVALID every 2nd cycle.
    @(negedge CLK);
    t0 = 1'b1;
    w0 = 1'b1;
    a0 = BASE + 8;
    s0 = 3'd3;
    d0 = D1;
    @(posedge CLK);
    #1;
    w0 = 1'b0;
    d0 = 64'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("b2b_rv", {64'd0, rv0}, 65'(i % 2));
      chk("b2b_rdy", {64'd0, rdy0}, 65'(i % 2));
      if (i % 2 == 1) begin
        chk("b2b_data", {rsp0, rd0}, {1'b0, D1});
      end
    end
    t0 = 1'b0;
    repeat (4) @(negedge CLK);

    chk("sb_empty", 65'(sb.size()), 65'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
